// File: rtl/sccb_init_seq_if.sv
// -----------------------------------------------------------------------------
// sccb_init_seq_if
// Request/response bundle between the init sequencer and the SCCB controller.
//   sccb_start_o      : request strobe, held high until the controller's done
//   sccb_rw_o         : 1 = write (3-phase), 0 = read (2-phase)
//   sccb_addr_o [7:0] : device ID
//   sccb_data_o [15:0]: {reg_addr, value}
//   sccb_data_i [7:0] : read data returned by the controller
//   sccb_done_i       : transfer complete, held until start is seen low
//   sccb_ack_error_i  : device did not acknowledge, valid with done
// master = sequencer side, slave = controller side.
// -----------------------------------------------------------------------------
interface sccb_init_seq_if;
   logic        sccb_start_o;
   logic        sccb_rw_o;
   logic [7:0]  sccb_addr_o;
   logic [15:0] sccb_data_o;
   logic [7:0]  sccb_data_i;
   logic        sccb_done_i;
   logic        sccb_ack_error_i;

   modport master (
      output sccb_start_o, sccb_rw_o, sccb_addr_o, sccb_data_o,
      input  sccb_data_i, sccb_done_i, sccb_ack_error_i
   );

   modport slave (
      input  sccb_start_o, sccb_rw_o, sccb_addr_o, sccb_data_o,
      output sccb_data_i, sccb_done_i, sccb_ack_error_i
   );
endinterface

// File: rtl/sccb_init_seq.sv
// -----------------------------------------------------------------------------
// sccb_init_seq
// Walks a camera register-initialisation ROM and issues one SCCB write per
// entry through the SCCB controller. Handles the controller start/done
// handshake, ack-error retries, inline delay entries (16'hF0nn = nn ms) and
// end of table (16'hFFFF, or running off the last ROM address).
//
// Ports:
//   clk_i, rst_i (async, active-low)
//   go_i            : 1-cycle pulse, starts the sequence at entry 0 (ignored
//                     while busy)
//   rom_addr_o      : ROM address; rom_data_i arrives one cycle later
//   sccb            : master side of sccb_init_seq_if
//   busy_o          : sequence in progress
//   done_o, error_o : sticky completion / abort flags, cleared by go_i
//   fail_index_o    : ROM index of the entry that exhausted its retries
//
// Optional feature macro: SCCB_INIT_READBACK_EN
//   When defined, every successful write is followed by a read of the same
//   register; a read ack error or data mismatch counts as a failed attempt
//   and the write is repeated. When undefined, sccb_rw_o is tied to 1.
// -----------------------------------------------------------------------------
module sccb_init_seq #(
   parameter logic [7:0] DEV_ID    = 8'h42,
   parameter int          ROM_AW    = 6,
   parameter int          MS_TICKS  = 100000,
   parameter int          MAX_RETRY = 3
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              go_i,
   output logic [ROM_AW-1:0] rom_addr_o,
   input  logic [15:0]       rom_data_i,
   sccb_init_seq_if.master   sccb,
   output logic              busy_o,
   output logic              done_o,
   output logic              error_o,
   output logic [ROM_AW-1:0] fail_index_o
);

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_DECODE, S_XFER, S_GAP, S_DELAY, S_FINISH, S_FAIL
   } state_t;

   localparam logic [ROM_AW-1:0] LAST_IDX  = '1;
   localparam logic [31:0]       MS_T      = 32'(MS_TICKS);
   localparam logic [7:0]        RETRY_MAX = 8'(MAX_RETRY);

   state_t            r_state;
   logic [ROM_AW-1:0] r_index;
   logic [7:0]        r_retry;
   logic [31:0]       r_dly;
   logic              r_start;
   logic              r_ack_err;
   logic [15:0]       r_data;
   logic              r_busy;
   logic              r_done;
   logic              r_error;
   logic [ROM_AW-1:0] r_fail_idx;
   logic              w_attempt_ok;

`ifdef SCCB_INIT_READBACK_EN
   logic              r_rw;
   logic [7:0]        r_rd_data;
   logic              w_need_read;

   // A write that was acked still needs its readback before it counts.
   assign w_need_read  = r_rw && !r_ack_err;
   assign w_attempt_ok = !r_ack_err && (r_rw || (r_rd_data == r_data[7:0]));
   assign sccb.sccb_rw_o = r_rw;
`else
   logic              w_unused_rdata;

   assign w_unused_rdata = ^sccb.sccb_data_i;
   assign w_attempt_ok   = !r_ack_err;
   assign sccb.sccb_rw_o = 1'b1;
`endif

   assign rom_addr_o       = r_index;
   assign sccb.sccb_start_o = r_start;
   assign sccb.sccb_addr_o  = DEV_ID;
   assign sccb.sccb_data_o  = r_data;
   assign busy_o           = r_busy;
   assign done_o           = r_done;
   assign error_o          = r_error;
   assign fail_index_o     = r_fail_idx;

   // Asynchronous reset drops sccb_start_o at once, which aborts the
   // controller; nothing is resumed afterwards.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_state    <= S_IDLE;
         r_index    <= '0;
         r_retry    <= '0;
         r_dly      <= '0;
         r_start    <= 1'b0;
         r_ack_err  <= 1'b0;
         r_data     <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_error    <= 1'b0;
         r_fail_idx <= '0;
`ifdef SCCB_INIT_READBACK_EN
         r_rw       <= 1'b1;
         r_rd_data  <= '0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               if (go_i) begin
                  r_done  <= 1'b0;
                  r_error <= 1'b0;
                  r_index <= '0;
                  r_retry <= '0;
                  r_busy  <= 1'b1;
                  r_state <= S_FETCH;
               end
            end

            // rom_addr_o already shows r_index; data is valid in DECODE.
            S_FETCH: r_state <= S_DECODE;

            S_DECODE: begin
               if (rom_data_i == 16'hFFFF) begin
                  r_state <= S_FINISH;
               end else if (rom_data_i[15:8] == 8'hF0) begin
                  if (rom_data_i[7:0] == 8'h00) begin
                     if (r_index == LAST_IDX) r_state <= S_FINISH;
                     else begin
                        r_index <= r_index + ROM_AW'(1);
                        r_state <= S_FETCH;
                     end
                  end else begin
                     r_dly   <= 32'(rom_data_i[7:0]) * MS_T;
                     r_state <= S_DELAY;
                  end
               end else begin
                  r_data  <= rom_data_i;
`ifdef SCCB_INIT_READBACK_EN
                  r_rw    <= 1'b1;
`endif
                  r_start <= 1'b1;
                  r_state <= S_XFER;
               end
            end

            S_XFER: begin
               if (sccb.sccb_done_i) begin
                  r_ack_err <= sccb.sccb_ack_error_i;
`ifdef SCCB_INIT_READBACK_EN
                  r_rd_data <= sccb.sccb_data_i;
`endif
                  r_start   <= 1'b0;
                  r_state   <= S_GAP;
               end
            end

            // The controller only releases done after it sees start low, so
            // no new request may be raised before done falls.
            S_GAP: begin
               if (!sccb.sccb_done_i) begin
`ifdef SCCB_INIT_READBACK_EN
                  if (w_need_read) begin
                     r_rw    <= 1'b0;
                     r_start <= 1'b1;
                     r_state <= S_XFER;
                  end else
`endif
                  if (w_attempt_ok) begin
                     r_retry <= '0;
                     if (r_index == LAST_IDX) r_state <= S_FINISH;
                     else begin
                        r_index <= r_index + ROM_AW'(1);
                        r_state <= S_FETCH;
                     end
                  end else if (r_retry < RETRY_MAX) begin
                     r_retry <= r_retry + 8'd1;
`ifdef SCCB_INIT_READBACK_EN
                     r_rw    <= 1'b1;
`endif
                     r_start <= 1'b1;
                     r_state <= S_XFER;
                  end else begin
                     r_fail_idx <= r_index;
                     r_state    <= S_FAIL;
                  end
               end
            end

            // Loaded with nn*MS_TICKS; spends exactly that many cycles here.
            S_DELAY: begin
               if (r_dly <= 32'd1) begin
                  r_dly <= '0;
                  if (r_index == LAST_IDX) r_state <= S_FINISH;
                  else begin
                     r_index <= r_index + ROM_AW'(1);
                     r_state <= S_FETCH;
                  end
               end else begin
                  r_dly <= r_dly - 32'd1;
               end
            end

            S_FINISH: begin
               r_done  <= 1'b1;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end

            S_FAIL: begin
               r_error <= 1'b1;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end

            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sccb_init_seq.sv
`timescale 1ns/1ps
module tb_sccb_init_seq;
   localparam int          ROM_AW    = 4;
   localparam int          DEPTH     = 16;
   localparam int          MAX_RETRY = 3;
   localparam int          MS_TICKS  = 10;
   localparam logic [7:0]  DEV_ID    = 8'h42;
`ifdef SCCB_INIT_READBACK_EN
   localparam int          RB = 1;
`else
   localparam int          RB = 0;
`endif

   typedef struct packed { logic rw; logic [15:0] data; } txn_t;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              go  = 1'b0;
   logic [ROM_AW-1:0] rom_addr;
   logic [ROM_AW-1:0] fail_index;
   logic [15:0]       rom_q;
   logic              busy, done, error;
   logic [15:0]       rom [0:DEPTH-1];

   sccb_init_seq_if bus ();

   sccb_init_seq #(
      .DEV_ID(DEV_ID), .ROM_AW(ROM_AW), .MS_TICKS(MS_TICKS), .MAX_RETRY(MAX_RETRY)
   ) dut (
      .clk_i(clk), .rst_i(rst), .go_i(go),
      .rom_addr_o(rom_addr), .rom_data_i(rom_q),
      .sccb(bus),
      .busy_o(busy), .done_o(done), .error_o(error), .fail_index_o(fail_index)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) rom_q <= rom[rom_addr];

   int tests = 0;
   int fails = 0;
   txn_t act_q[$];
   txn_t exp_q[$];
   logic [15:0] nack_val = 16'hFFFF;
   logic [15:0] bad_val  = 16'hFFFF;
   int nack_init = 0, bad_init = 0, nack_left = 0, bad_left = 0;
   bit exp_done, exp_err;
   int exp_fidx;
   int t_go = 0, t_end = 0, t_first_start = -1, t_last_fall = 0;
   int viol_start = 0, viol_both = 0;

   // Behavioural SCCB controller: random latency, done held until start low.
   initial begin
      int  m_state;
      int  m_lat;
      bit  prev_start;
      m_state = 0; m_lat = 0; prev_start = 0;
      bus.sccb_done_i = 0; bus.sccb_ack_error_i = 0; bus.sccb_data_i = 0;
      forever begin
         @(negedge clk);
         if (done && error) viol_both++;
         if (bus.sccb_start_o && !prev_start) begin
            if (bus.sccb_done_i) viol_start++;
            if (t_first_start < 0) t_first_start = cyc;
         end
         prev_start = bus.sccb_start_o;
         if (!rst) begin
            m_state = 0; bus.sccb_done_i = 0; bus.sccb_ack_error_i = 0;
         end else begin
            case (m_state)
               0: if (bus.sccb_start_o) begin
                     m_lat = int'($urandom_range(1, 4)); m_state = 1;
                  end
               1: if (!bus.sccb_start_o) m_state = 0;
                  else begin
                     m_lat--;
                     if (m_lat == 0) begin
                        act_q.push_back({bus.sccb_rw_o, bus.sccb_data_o});
                        bus.sccb_ack_error_i = 0;
                        bus.sccb_data_i = bus.sccb_data_o[7:0];
                        if (bus.sccb_rw_o && bus.sccb_data_o == nack_val && nack_left > 0) begin
                           bus.sccb_ack_error_i = 1; nack_left--;
                        end
                        if (!bus.sccb_rw_o && bus.sccb_data_o == bad_val && bad_left > 0) begin
                           bus.sccb_data_i = (bus.sccb_data_o[7:0] == 8'h00) ? 8'hFF : 8'h00;
                           bad_left--;
                        end
                        bus.sccb_done_i = 1; m_state = 2;
                     end
                  end
               default: if (!bus.sccb_start_o) begin
                     bus.sccb_done_i = 0; bus.sccb_ack_error_i = 0;
                     t_last_fall = cyc; m_state = 0;
                  end
            endcase
         end
      end
   end

   // Reference: what the table should produce as a list of bus transfers.
   task automatic model_run();
      int  nl, bl, tries;
      bit  ok;
      nl = nack_init; bl = bad_init;
      exp_q.delete(); exp_done = 0; exp_err = 0; exp_fidx = 0;
      for (int i = 0; i < DEPTH; i++) begin
         if (rom[i] == 16'hFFFF) begin exp_done = 1; return; end
         if (rom[i][15:8] == 8'hF0) continue;
         tries = 0;
         forever begin
            exp_q.push_back({1'b1, rom[i]});
            ok = !(rom[i] == nack_val && nl > 0);
            if (!ok) nl--;
            if (RB != 0 && ok) begin
               exp_q.push_back({1'b0, rom[i]});
               ok = !(rom[i] == bad_val && bl > 0);
               if (!ok) bl--;
            end
            if (ok) break;
            tries++;
            if (tries > MAX_RETRY) begin exp_err = 1; exp_fidx = i; return; end
         end
      end
      exp_done = 1;
   endtask

   task automatic setup(input logic [15:0] e0, input logic [15:0] e1,
                        input logic [15:0] e2, input logic [15:0] e3);
      for (int i = 0; i < DEPTH; i++) rom[i] = 16'hFFFF;
      rom[0] = e0; rom[1] = e1; rom[2] = e2; rom[3] = e3;
      nack_val = 16'hFFFF; nack_init = 0; bad_val = 16'hFFFF; bad_init = 0;
   endtask

   task automatic run_seq(input bit mid_go, output bit timeout);
      act_q.delete();
      nack_left = nack_init; bad_left = bad_init;
      t_first_start = -1;
      model_run();
      @(negedge clk); go = 1; t_go = cyc;
      @(negedge clk); go = 0;
      timeout = 1;
      for (int c = 0; c < 4000; c++) begin
         @(negedge clk);
         go = (mid_go && c == 6);
         if (!busy && (done || error)) begin timeout = 0; t_end = cyc; break; end
      end
      go = 0;
   endtask

   task automatic test_reset();
      tests++; if (bus.sccb_start_o !== 1'b0) begin fails++; $display("FAIL reset_start got %b want 0", bus.sccb_start_o); end
      tests++; if (bus.sccb_rw_o !== 1'b1) begin fails++; $display("FAIL reset_rw got %b want 1", bus.sccb_rw_o); end
      tests++; if (bus.sccb_addr_o !== DEV_ID) begin fails++; $display("FAIL reset_addr got %h want %h", bus.sccb_addr_o, DEV_ID); end
      tests++; if (bus.sccb_data_o !== 16'h0) begin fails++; $display("FAIL reset_data got %h want 0", bus.sccb_data_o); end
      tests++; if ({busy, done, error} !== 3'b000) begin fails++; $display("FAIL reset_flags got %b want 000", {busy, done, error}); end
      tests++; if (fail_index !== '0 || rom_addr !== '0) begin fails++; $display("FAIL reset_index got %h/%h want 0/0", fail_index, rom_addr); end
      @(negedge clk); rst = 1;
      repeat (3) @(negedge clk);
      tests++; if ({busy, bus.sccb_start_o} !== 2'b00) begin fails++; $display("FAIL reset_idle got %b want 00", {busy, bus.sccb_start_o}); end
   endtask

   task automatic test_basic();
      bit to;
      txn_t a0;
      setup(16'h1280, 16'h1100, 16'hFFFF, 16'hFFFF);
      run_seq(0, to);
      a0 = (act_q.size() > 0) ? act_q[0] : '0;
      tests++; if (to) begin fails++; $display("FAIL basic_timeout got busy=%b want done", busy); end
      tests++; if ({done, error, busy} !== 3'b100) begin fails++; $display("FAIL basic_flags got %b want 100", {done, error, busy}); end
      tests++; if (act_q.size() != 2 * (1 + RB)) begin fails++; $display("FAIL basic_count got %0d want %0d", act_q.size(), 2 * (1 + RB)); end
      tests++; if (a0 !== {1'b1, 16'h1280}) begin fails++; $display("FAIL basic_first got %h want 11280", a0); end
      for (int i = 0; i < exp_q.size(); i++) begin
         tests++;
         if (i >= act_q.size() || act_q[i] !== exp_q[i]) begin
            fails++; $display("FAIL basic_txn%0d got %h want %h", i, (i < act_q.size()) ? act_q[i] : '0, exp_q[i]);
         end
      end
      tests++; if (t_end - t_last_fall > 5) begin fails++; $display("FAIL basic_latency got %0d cycles want <=5", t_end - t_last_fall); end
   endtask

   task automatic test_delay();
      bit to;
      setup(16'hF002, 16'h1100, 16'hFFFF, 16'hFFFF);
      run_seq(0, to);
      tests++; if (to || done !== 1'b1) begin fails++; $display("FAIL delay_done got %b want 1", done); end
      tests++; if (t_first_start < 0 || t_first_start - t_go < 20) begin fails++; $display("FAIL delay_gap got %0d cycles want >=20", t_first_start - t_go); end
      tests++; if (act_q.size() != exp_q.size()) begin fails++; $display("FAIL delay_count got %0d want %0d", act_q.size(), exp_q.size()); end
   endtask

   task automatic test_retry();
      bit to;
      int n;
      setup(16'h1280, 16'h1100, 16'h1234, 16'hFFFF);
      nack_val = 16'h1100; nack_init = 2;
      run_seq(0, to);
      n = 0;
      foreach (act_q[i]) if (act_q[i] == {1'b1, 16'h1100}) n++;
      tests++; if (n != 3) begin fails++; $display("FAIL retry_pulses got %0d want 3", n); end
      tests++; if (to || {done, error} !== 2'b10) begin fails++; $display("FAIL retry_flags got %b want 10", {done, error}); end
      tests++; if (act_q.size() != exp_q.size()) begin fails++; $display("FAIL retry_count got %0d want %0d", act_q.size(), exp_q.size()); end
   endtask

   task automatic test_fail();
      bit to;
      int n;
      setup(16'h1280, 16'h1100, 16'h1234, 16'h1300);
      nack_val = 16'h1234; nack_init = 1000;
      run_seq(0, to);
      n = 0;
      foreach (act_q[i]) if (act_q[i] == {1'b1, 16'h1234}) n++;
      tests++; if (n != MAX_RETRY + 1) begin fails++; $display("FAIL fail_attempts got %0d want %0d", n, MAX_RETRY + 1); end
      tests++; if (to || {done, error} !== 2'b01) begin fails++; $display("FAIL fail_flags got %b want 01", {done, error}); end
      tests++; if (fail_index !== ROM_AW'(2)) begin fails++; $display("FAIL fail_index got %0d want 2", fail_index); end
      tests++; if (act_q.size() != exp_q.size()) begin fails++; $display("FAIL fail_count got %0d want %0d", act_q.size(), exp_q.size()); end
   endtask

   task automatic test_go_ignored();
      bit to;
      setup(16'h1280, 16'h1100, 16'h1234, 16'hFFFF);
      run_seq(1, to);
      tests++; if (act_q.size() != exp_q.size()) begin fails++; $display("FAIL go_ignored_count got %0d want %0d", act_q.size(), exp_q.size()); end
      tests++; if (to || done !== 1'b1) begin fails++; $display("FAIL go_ignored_done got %b want 1", done); end
   endtask

   task automatic test_wrap();
      bit to;
      setup(16'h0, 16'h0, 16'h0, 16'h0);
      for (int i = 0; i < DEPTH; i++) rom[i] = {8'(i + 8'h10), 8'($urandom)};
      run_seq(0, to);
      tests++; if (act_q.size() != DEPTH * (1 + RB)) begin fails++; $display("FAIL wrap_count got %0d want %0d", act_q.size(), DEPTH * (1 + RB)); end
      tests++; if (to || {done, error} !== 2'b10) begin fails++; $display("FAIL wrap_flags got %b want 10", {done, error}); end
   endtask

`ifdef SCCB_INIT_READBACK_EN
   task automatic test_readback();
      bit to;
      int n;
      setup(16'h1280, 16'h1100, 16'hFFFF, 16'hFFFF);
      bad_val = 16'h1280; bad_init = 1;
      run_seq(0, to);
      n = 0;
      foreach (act_q[i]) if (act_q[i] == {1'b1, 16'h1280}) n++;
      tests++; if (n != 2) begin fails++; $display("FAIL readback_rewrites got %0d want 2", n); end
      tests++; if (act_q.size() != 6) begin fails++; $display("FAIL readback_count got %0d want 6", act_q.size()); end
      tests++; if (to || {done, error} !== 2'b10) begin fails++; $display("FAIL readback_flags got %b want 10", {done, error}); end
   endtask
`endif

   task automatic test_random();
      bit to;
      int len;
      for (int it = 0; it < 25; it++) begin
         setup(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
         len = int'($urandom_range(1, DEPTH));
         for (int i = 0; i < len; i++) begin
            if ($urandom_range(0, 6) == 0) rom[i] = 16'hF000 | 16'($urandom_range(0, 2));
            else rom[i] = {8'($urandom_range(0, 239)), 8'($urandom)};
         end
         nack_val  = rom[$urandom_range(0, len - 1)];
         nack_init = int'($urandom_range(0, 5));
         bad_val   = rom[$urandom_range(0, len - 1)];
         bad_init  = int'($urandom_range(0, 3));
         run_seq(0, to);
         tests++;
         if (to || done !== exp_done || error !== exp_err) begin
            fails++; $display("FAIL rand%0d_flags got %b%b want %b%b", it, done, error, exp_done, exp_err);
         end
         if (exp_err) begin
            tests++;
            if (fail_index !== ROM_AW'(exp_fidx)) begin fails++; $display("FAIL rand%0d_fidx got %0d want %0d", it, fail_index, exp_fidx); end
         end
         tests++;
         if (act_q.size() != exp_q.size()) begin fails++; $display("FAIL rand%0d_count got %0d want %0d", it, act_q.size(), exp_q.size()); end
         for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
            tests++;
            if (act_q[i] !== exp_q[i]) begin fails++; $display("FAIL rand%0d_txn%0d got %h want %h", it, i, act_q[i], exp_q[i]); end
         end
      end
   endtask

   task automatic test_reset_mid();
      bit seen;
      int resumed;
      setup(16'h1280, 16'h1100, 16'hFFFF, 16'hFFFF);
      act_q.delete();
      @(negedge clk); go = 1;
      @(negedge clk); go = 0;
      seen = 0;
      for (int c = 0; c < 100; c++) begin
         if (bus.sccb_start_o) begin seen = 1; break; end
         @(negedge clk);
      end
      tests++; if (!seen) begin fails++; $display("FAIL rstmid_xfer got no start want start"); end
      #2 rst = 0;
      #1;
      tests++; if (bus.sccb_start_o !== 1'b0) begin fails++; $display("FAIL rstmid_start got %b want 0", bus.sccb_start_o); end
      tests++; if ({busy, done, error} !== 3'b000) begin fails++; $display("FAIL rstmid_flags got %b want 000", {busy, done, error}); end
      tests++; if (bus.sccb_rw_o !== 1'b1 || bus.sccb_addr_o !== DEV_ID) begin fails++; $display("FAIL rstmid_rwaddr got %b/%h want 1/%h", bus.sccb_rw_o, bus.sccb_addr_o, DEV_ID); end
      tests++; if (bus.sccb_data_o !== 16'h0 || rom_addr !== '0 || fail_index !== '0) begin fails++; $display("FAIL rstmid_regs got %h/%h/%h want 0/0/0", bus.sccb_data_o, rom_addr, fail_index); end
      @(negedge clk); rst = 1;
      resumed = 0;
      repeat (20) begin
         @(negedge clk);
         if (bus.sccb_start_o || busy) resumed++;
      end
      tests++; if (resumed != 0) begin fails++; $display("FAIL rstmid_resume got %0d active cycles want 0", resumed); end
   endtask

   task automatic test_invariants();
      tests++; if (viol_both != 0) begin fails++; $display("FAIL done_and_error got %0d cycles want 0", viol_both); end
      tests++; if (viol_start != 0) begin fails++; $display("FAIL start_while_done got %0d want 0", viol_start); end
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) rom[i] = 16'hFFFF;
      rst = 0;
      repeat (3) @(negedge clk);
      test_reset();
      test_basic();
      test_delay();
      test_retry();
      test_fail();
      test_go_ignored();
      test_wrap();
`ifdef SCCB_INIT_READBACK_EN
      test_readback();
`endif
      test_random();
      test_reset_mid();
      test_invariants();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
